// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - multi-cycle load/store unit with req/gnt/rvalid memory handshake
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned H/W accesses fault instead of aligning down)
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_en,
  input  logic        st_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_out,
  input  logic [31:0] wdata,
  output logic [31:0] dataR,
  output logic        stall,
  output logic        fault,
  output logic        bus_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Counter only needs to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [1:0]    state;
  logic [31:0]   addr_q;
  logic [2:0]    f3_q;
  logic [31:0]   wdata_q;
  logic          ld_q;
  logic [CW-1:0] cnt;

  logic          access;
  logic          is_store;
  logic          f3_bad;
  logic          misalign;
  logic          illegal;
  logic          go;
  logic [31:0]   addr_aligned;
  logic [31:0]   lane;
  logic [31:0]   ld_ext;
  logic [3:0]    be_q;
  logic [31:0]   wrep_q;
  logic          timeout_hit;

  // Request decode: legality check and address alignment of the incoming access.
  always_comb begin
    access   = ld_en | st_en;
    is_store = st_en & ~ld_en;
    f3_bad   = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (is_store && funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((funct3[1:0] == 2'b01) && alu_out[0]) ||
               ((funct3[1:0] == 2'b10) && (alu_out[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    illegal = f3_bad | misalign;
    go      = (state == S_IDLE) && access && !illegal;
    case (funct3[1:0])
      2'b01:   addr_aligned = {alu_out[31:1], 1'b0};
      2'b10:   addr_aligned = {alu_out[31:2], 2'b00};
      default: addr_aligned = alu_out;
    endcase
  end

  // Core-facing status: stall while an access is accepted or in flight, fault on refusal.
  always_comb begin
    stall = go || (state == S_REQ) || (state == S_WAIT);
    fault = (state == S_IDLE) && access && illegal;
  end

  // Lane enables, replicated store data and extended load data from the captured access.
  always_comb begin
    case (f3_q[1:0])
      2'b00:   be_q = 4'b0001 << addr_q[1:0];
      2'b01:   be_q = 4'b0011 << addr_q[1:0];
      default: be_q = 4'b1111;
    endcase
    case (f3_q[1:0])
      2'b00:   wrep_q = {4{wdata_q[7:0]}};
      2'b01:   wrep_q = {2{wdata_q[15:0]}};
      default: wrep_q = wdata_q;
    endcase
    lane = mem_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_ext = {24'h0, lane[7:0]};
      3'b101:  ld_ext = {16'h0, lane[15:0]};
      default: ld_ext = mem_rdata;
    endcase
    timeout_hit = (cnt == CW'(TIMEOUT - 1));
  end

  // Memory request outputs are only non-zero while the request is presented.
  always_comb begin
    mem_req   = (state == S_REQ);
    mem_we    = mem_req & ~ld_q;
    mem_be    = mem_req ? be_q : 4'b0000;
    mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
    mem_wdata = mem_req ? wrep_q : 32'h0;
  end

  // Access FSM: capture, request, wait for response or timeout, one-cycle retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr_q  <= 32'h0;
      f3_q    <= 3'b000;
      wdata_q <= 32'h0;
      ld_q    <= 1'b0;
      cnt     <= '0;
      dataR   <= 32'h0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            addr_q  <= addr_aligned;
            f3_q    <= funct3;
            wdata_q <= wdata;
            ld_q    <= ld_en;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            cnt   <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            if (ld_q) dataR <= ld_ext;
            state <= S_DONE;
          end else if (timeout_hit) begin
            dataR   <= 32'h0;
            bus_err <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ld_en;
  logic        st_en;
  logic [2:0]  funct3;
  logic [31:0] alu_out;
  logic [31:0] wdata;
  logic [31:0] dataR;
  logic        stall;
  logic        fault;
  logic        bus_err;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  lsu_mem_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .st_en(st_en), .funct3(funct3),
    .alu_out(alu_out), .wdata(wdata), .dataR(dataR), .stall(stall), .fault(fault),
    .bus_err(bus_err), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one full access with gnt in REQ and rvalid in the first WAIT cycle; ends in DONE.
  task automatic access(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        output logic s0, output logic req, output logic we,
                        output logic [3:0] be, output logic [31:0] ad, output logic [31:0] wdo);
    ld_en = ld; st_en = st; funct3 = f3; alu_out = a; wdata = wd;
    #1;
    s0 = stall;
    tick;
    ld_en = 1'b0; st_en = 1'b0; mem_gnt = 1'b1;
    #1;
    req = mem_req; we = mem_we; be = mem_be; ad = mem_addr; wdo = mem_wdata;
    tick;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
    tick;
    mem_rvalid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ld_en = 0; st_en = 0; funct3 = 0; alu_out = 0; wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    tick; tick;
    checks++;
    if ({dataR, stall, fault, bus_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_values dataR=%h stall=%b fault=%b bus_err=%b req=%b we=%b be=%b addr=%h wd=%h exp all 0",
               dataR, stall, fault, bus_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_lw;
    ld_en = 1; funct3 = 3'b010; alu_out = 32'h100;
    #1;
    checks++;
    if (stall !== 1'b1 || fault !== 1'b0) begin
      errors++; $display("FAIL lw_issue_stall stall=%b fault=%b exp 1 0", stall, fault);
    end
    tick;
    ld_en = 0; mem_gnt = 1;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b1111 || mem_addr !== 32'h100 || stall !== 1'b1) begin
      errors++;
      $display("FAIL lw_req req=%b we=%b be=%b addr=%h stall=%b exp 1 0 1111 00000100 1",
               mem_req, mem_we, mem_be, mem_addr, stall);
    end
    tick;
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL lw_wait req=%b stall=%b exp 0 1", mem_req, stall);
    end
    tick;
    mem_rvalid = 0;
    #1;
    checks++;
    if (stall !== 1'b0 || dataR !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_done stall=%b dataR=%h exp 0 deadbeef", stall, dataR);
    end
    tick;
  endtask

  task automatic test_byte_loads;
    logic s0, req, we; logic [3:0] be; logic [31:0] ad, wdo;
    access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, s0, req, we, be, ad, wdo);
    checks++;
    if (be !== 4'b1000 || ad !== 32'h100 || dataR !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb be=%b addr=%h dataR=%h exp 1000 00000100 ffffff80", be, ad, dataR);
    end
    tick;
    access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, s0, req, we, be, ad, wdo);
    checks++;
    if (be !== 4'b1000 || dataR !== 32'h00000080) begin
      errors++; $display("FAIL lbu be=%b dataR=%h exp 1000 00000080", be, dataR);
    end
    tick;
  endtask

  task automatic test_store_half;
    logic s0, req, we; logic [3:0] be; logic [31:0] ad, wdo;
    access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h55555555, s0, req, we, be, ad, wdo);
    checks++;
    if (req !== 1'b1 || we !== 1'b1 || be !== 4'b1100 || wdo !== 32'hABCDABCD || ad !== 32'h200) begin
      errors++;
      $display("FAIL sh req=%b we=%b be=%b wdata=%h addr=%h exp 1 1 1100 abcdabcd 00000200", req, we, be, wdo, ad);
    end
    checks++;
    if (dataR !== 32'h00000080 || stall !== 1'b0) begin
      errors++; $display("FAIL sh_dataR dataR=%h stall=%b exp 00000080 0", dataR, stall);
    end
    tick;
  endtask

  task automatic test_misalign;
    logic s0, req, we; logic [3:0] be; logic [31:0] ad, wdo;
`ifdef LSU_MISALIGN_TRAP_EN
    ld_en = 1; funct3 = 3'b010; alu_out = 32'h102;
    #1;
    checks++;
    if (fault !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL misalign_trap fault=%b stall=%b exp 1 0", fault, stall);
    end
    tick;
    ld_en = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || fault !== 1'b0 || dataR !== 32'h00000080) begin
      errors++; $display("FAIL misalign_noreq req=%b fault=%b dataR=%h exp 0 0 00000080", mem_req, fault, dataR);
    end
    access(1, 0, 3'b010, 32'h100, 32'h0, 32'h11223344, s0, req, we, be, ad, wdo);
    tick;
`else
    access(1, 0, 3'b010, 32'h102, 32'h0, 32'h11223344, s0, req, we, be, ad, wdo);
    checks++;
    if (req !== 1'b1 || ad !== 32'h100 || be !== 4'b1111 || dataR !== 32'h11223344) begin
      errors++;
      $display("FAIL misalign_align req=%b addr=%h be=%b dataR=%h exp 1 00000100 1111 11223344", req, ad, be, dataR);
    end
    tick;
`endif
  endtask

  task automatic test_illegal;
    ld_en = 1; funct3 = 3'b011; alu_out = 32'h400;
    #1;
    checks++;
    if (fault !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL illegal_ld fault=%b stall=%b exp 1 0", fault, stall);
    end
    tick;
    ld_en = 0; st_en = 1; funct3 = 3'b100;
    #1;
    checks++;
    if (fault !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL illegal_st fault=%b stall=%b req=%b exp 1 0 0", fault, stall, mem_req);
    end
    tick;
    st_en = 0;
    #1;
    checks++;
    if (fault !== 1'b0 || mem_req !== 1'b0 || dataR !== 32'h11223344) begin
      errors++; $display("FAIL illegal_after fault=%b req=%b dataR=%h exp 0 0 11223344", fault, mem_req, dataR);
    end
  endtask

  task automatic test_timeout;
    ld_en = 1; funct3 = 3'b010; alu_out = 32'h500;
    tick;
    ld_en = 0; mem_gnt = 1;
    tick;
    mem_gnt = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (stall !== 1'b1 || bus_err !== 1'b0) begin
        errors++; $display("FAIL timeout_wait%0d stall=%b bus_err=%b exp 1 0", i, stall, bus_err);
      end
      tick;
    end
    checks++;
    if (bus_err !== 1'b1 || dataR !== 32'h0 || stall !== 1'b0) begin
      errors++; $display("FAIL timeout_done bus_err=%b dataR=%h stall=%b exp 1 0 0", bus_err, dataR, stall);
    end
    tick;
    mem_rvalid = 1; mem_rdata = 32'h77777777;
    #1;
    checks++;
    if (bus_err !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse bus_err=%b stall=%b exp 0 0", bus_err, stall);
    end
    tick;
    mem_rvalid = 0;
    #1;
    checks++;
    if (dataR !== 32'h0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL timeout_late dataR=%h req=%b exp 0 0", dataR, mem_req);
    end
  endtask

  task automatic test_back_to_back;
    logic s0, req, we; logic [3:0] be; logic [31:0] ad, wdo;
    access(1, 1, 3'b001, 32'h102, 32'h0, 32'h80010000, s0, req, we, be, ad, wdo);
    checks++;
    if (we !== 1'b0 || be !== 4'b1100 || dataR !== 32'hFFFF8001) begin
      errors++; $display("FAIL lh_ld_wins we=%b be=%b dataR=%h exp 0 1100 ffff8001", we, be, dataR);
    end
    tick;
    access(1, 0, 3'b101, 32'h100, 32'h0, 32'h1234F00F, s0, req, we, be, ad, wdo);
    checks++;
    if (s0 !== 1'b1 || req !== 1'b1 || be !== 4'b0011 || dataR !== 32'h0000F00F) begin
      errors++; $display("FAIL b2b_lhu stall0=%b req=%b be=%b dataR=%h exp 1 1 0011 0000f00f", s0, req, be, dataR);
    end
    tick;
  endtask

  task automatic test_reset_mid_wait;
    ld_en = 1; funct3 = 3'b010; alu_out = 32'h300;
    tick;
    ld_en = 0; mem_gnt = 1;
    tick;
    mem_gnt = 0;
    rst_n = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || dataR !== 32'h0) begin
      errors++; $display("FAIL rst_mid req=%b stall=%b dataR=%h exp 0 0 0", mem_req, stall, dataR);
    end
    tick;
    rst_n = 1; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    tick;
    mem_rvalid = 0;
    #1;
    checks++;
    if (dataR !== 32'h0 || stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL rst_late_rvalid dataR=%h stall=%b req=%b exp 0 0 0", dataR, stall, mem_req);
    end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_byte_loads;
    test_store_half;
    test_misalign;
    test_illegal;
    test_timeout;
    test_back_to_back;
    test_reset_mid_wait;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
